// File: rtl/lfsr_rand_gen_63.sv
// Purpose : 6-bit Fibonacci LFSR (x^6 + x^5 + 1), period 63, never outputs zero.
// Latency : rnd is the state register itself; each rising clk edge advances one step.
// Backpress: none; free-running, steps every clk edge while reset_n is high.
//
// Ports:
//   clk      game update clock; the state advances on every rising edge
//   reset_n  asynchronous active-low reset; loads seed while low
//   seed     initial state, only sampled while reset_n is low (zero is replaced by ZERO_SUB)
//   rnd      current LFSR state, unsigned, never zero
module lfsr_rand_gen_63 #(
  // The tap set (bits 5 and 4) is only maximal-length for a width of 6.
  parameter int unsigned WIDTH = 6,
  parameter logic [5:0] ZERO_SUB = 6'b000001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] rnd
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] seed_eff;
  logic             fb;

  // An all-zero seed would lock the LFSR, so it is substituted.
  assign seed_eff = (seed == '0) ? ZERO_SUB : seed;

  // Feedback for x^6 + x^5 + 1.
  assign fb = q[5] ^ q[4];

  // While reset_n is low, the async branch is taken on every event, including
  // clk edges, so q tracks seed across edges held in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= seed_eff;
    end else if (q == '0) begin
      // Lockup recovery; unreachable from any legal state.
      q <= ZERO_SUB;
    end else begin
      q <= {q[4:0], fb};
    end
  end

  assign rnd = q;

endmodule

// File: tb/tb_lfsr_rand_gen_63.sv
module tb_lfsr_rand_gen_63;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] seed = 6'h26;
  logic [5:0] rnd;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  lfsr_rand_gen_63 dut (
    .clk(clk),
    .reset_n(reset_n),
    .seed(seed),
    .rnd(rnd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Independent reference: x^6 + x^5 + 1 Fibonacci step.
  function automatic logic [5:0] model_next(input logic [5:0] s);
    logic [5:0] r;
    if (s == 6'd0) r = 6'd1;
    else           r = {s[4:0], s[5] ^ s[4]};
    return r;
  endfunction

  // Pulse reset between edges; leaves inputs stable at a negedge.
  task automatic do_reset(input logic [5:0] s);
    @(negedge clk);
    seed = s;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [5:0] e;
    seed = 6'h26;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rnd !== 6'h26) begin
      errors++;
      $display("FAIL reset_async: rnd=%h expected=%h", rnd, 6'h26);
    end
    // Held in reset across edges: stays at seed.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = 6'h26;
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL reset_hold: rnd=%h expected=%h", rnd, e);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_seed_a;
    logic [5:0] e;
    do_reset(6'h26);
    exp_q.push_back(6'h26); exp_q.push_back(6'h0D); exp_q.push_back(6'h1A);
    exp_q.push_back(6'h35); exp_q.push_back(6'h2A);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL seed_a step%0d: rnd=%h expected=%h", i, rnd, e);
      end
    end
  endtask

  task automatic test_seed_b;
    logic [5:0] e;
    do_reset(6'h29);
    exp_q.push_back(6'h29); exp_q.push_back(6'h13);
    exp_q.push_back(6'h27); exp_q.push_back(6'h0F);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL seed_b step%0d: rnd=%h expected=%h", i, rnd, e);
      end
    end
  endtask

  task automatic test_zero_seed;
    logic [5:0] e;
    do_reset(6'h00);
    exp_q.push_back(6'h01); exp_q.push_back(6'h02); exp_q.push_back(6'h04);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL zero_seed step%0d: rnd=%h expected=%h", i, rnd, e);
      end
    end
  endtask

  task automatic test_period;
    bit         seen[64];
    int         dups;
    int         zeros;
    int         nseen;
    logic [5:0] m;
    logic [5:0] first;
    logic [5:0] e;
    dups = 0; zeros = 0; nseen = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    do_reset(6'h15);
    m = 6'h15;
    for (int i = 1; i <= 64; i++) begin
      m = model_next(m);
      exp_q.push_back(m);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL period_seq edge%0d: rnd=%h expected=%h", i, rnd, e);
      end
      if (i == 1) first = rnd;
      if (i <= 63) begin
        if (rnd == 6'd0) zeros++;
        else if (seen[rnd]) dups++;
        else begin seen[rnd] = 1'b1; nseen++; end
      end
      if (i == 63) begin
        checks++;
        if (rnd !== 6'h15) begin
          errors++;
          $display("FAIL period_return: rnd=%h expected=%h", rnd, 6'h15);
        end
      end
      if (i == 64) begin
        checks++;
        if (rnd !== first) begin
          errors++;
          $display("FAIL period_edge64: rnd=%h expected=%h", rnd, first);
        end
      end
    end
    checks++;
    if (nseen != 63 || dups != 0 || zeros != 0) begin
      errors++;
      $display("FAIL period_unique: distinct=%0d dups=%0d zeros=%0d expected 63/0/0", nseen, dups, zeros);
    end
  endtask

  task automatic test_async_reset;
    logic [5:0] e;
    do_reset(6'h0B);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rnd !== 6'h0B) begin
      errors++;
      $display("FAIL async_mid: rnd=%h expected=%h", rnd, 6'h0B);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = 6'h0B;
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL async_hold: rnd=%h expected=%h", rnd, e);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    e = model_next(6'h0B);
    checks++;
    if (rnd !== e) begin
      errors++;
      $display("FAIL async_release: rnd=%h expected=%h", rnd, e);
    end
    // Zero seed applied mid-run.
    #2 seed = 6'h00; reset_n = 1'b0;
    #1;
    checks++;
    if (rnd !== 6'h01) begin
      errors++;
      $display("FAIL async_zero: rnd=%h expected=%h", rnd, 6'h01);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_seed_change;
    logic [5:0] e;
    do_reset(6'h26);
    @(negedge clk);
    seed = 6'h29;
    exp_q.push_back(6'h0D); exp_q.push_back(6'h1A); exp_q.push_back(6'h35);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (rnd !== e) begin
        errors++;
        $display("FAIL seed_change step%0d: rnd=%h expected=%h", i, rnd, e);
      end
    end
    do_reset(6'h29);
    checks++;
    if (rnd !== 6'h29) begin
      errors++;
      $display("FAIL seed_reload: rnd=%h expected=%h", rnd, 6'h29);
    end
  endtask

  initial begin
    test_reset();
    test_seed_a();
    test_seed_b();
    test_zero_seed();
    test_period();
    test_async_reset();
    test_seed_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
